// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the N-port memory arbiter.
//   MEM_ARB_MAX_MST : largest supported requestor count
//   CONFLICT_CNT_W  : width of the saturating contention counter
//   idx_w()         : index width needed to address n requestors (minimum 1)
package mem_arb_pkg;

    localparam int unsigned MEM_ARB_MAX_MST = 8;
    localparam int unsigned CONFLICT_CNT_W  = 16;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_n_rr_picker.sv
// Round-robin picker: grants the first asserted request at or after ptr, wrapping modulo NUM_REQ.
// Ports:
//   req : request vector
//   ptr : starting (highest-priority) index
//   gnt : one-hot grant (all zero when no request)
//   idx : binary index of the grant (0 when no request)
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IW     = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IW'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arb_n.sv
// N-port round-robin arbiter in front of a single memory port.
// Zero-latency grant, lock on memory stall, one-cycle read data return, saturating contention
// counter. Define MEM_ARB_HOLD_EN to let a granted requestor keep the port for up to HOLD_MAX
// consecutive acceptances.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   s_cs/s_we/s_addr/s_byte/s_di : per-requestor request fields
//   s_do, s_rvalid           : broadcast read data, one-hot read-data-valid
//   s_busy                   : per-requestor stall
//   m_cs/m_we/m_addr/m_byte/m_di : request to memory (fields of granted requestor)
//   m_do, m_busy             : memory read data (one cycle after acceptance), memory stall
//   conflict_cnt             : cycles with two or more requests, saturating
module mem_arb_n
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_MST  = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned HOLD_MAX = 4,
    localparam int unsigned BE_W    = DATA_W / 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MST-1:0]                s_cs,
    input  logic [NUM_MST-1:0]                s_we,
    input  logic [NUM_MST-1:0][ADDR_W-1:0]    s_addr,
    input  logic [NUM_MST-1:0][BE_W-1:0]      s_byte,
    input  logic [NUM_MST-1:0][DATA_W-1:0]    s_di,
    output logic [DATA_W-1:0]                 s_do,
    output logic [NUM_MST-1:0]                s_rvalid,
    output logic [NUM_MST-1:0]                s_busy,
    output logic                              m_cs,
    output logic                              m_we,
    output logic [ADDR_W-1:0]                 m_addr,
    output logic [BE_W-1:0]                   m_byte,
    output logic [DATA_W-1:0]                 m_di,
    input  logic [DATA_W-1:0]                 m_do,
    input  logic                              m_busy,
    output logic [CONFLICT_CNT_W-1:0]         conflict_cnt
);

    localparam int unsigned IW = idx_w(NUM_MST);

    if (NUM_MST < 2 || NUM_MST > MEM_ARB_MAX_MST) begin : g_num_mst_chk
        $error("mem_arb_n: NUM_MST out of range");
    end
    if (HOLD_MAX < 1) begin : g_hold_max_chk
        $error("mem_arb_n: HOLD_MAX must be at least 1");
    end

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(NUM_MST - 1)) ? '0 : v + IW'(1);
    endfunction

    logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
    logic                      lock_q, lock_d;
    logic [IW-1:0]             lock_idx_q, lock_idx_d;
    logic [NUM_MST-1:0]        rd_owner_q, rd_owner_d;
    logic [CONFLICT_CNT_W-1:0] conflict_q, conflict_d;

    logic [NUM_MST-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               lock_hit;
    logic [IW-1:0]      g;
    logic [NUM_MST-1:0] g_oh;
    logic               accept;
    logic               multi_req;

    rr_picker #(
        .NUM_REQ (NUM_MST)
    ) u_picker (
        .req (s_cs),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // A locked requestor that dropped s_cs loses the lock this cycle; normal arbitration applies.
    assign lock_hit = lock_q & s_cs[lock_idx_q];
    assign g        = lock_hit ? lock_idx_q : pick_idx;
    assign g_oh     = lock_hit ? (NUM_MST'(1) << lock_idx_q) : pick_gnt;

    assign m_cs   = |s_cs;
    assign m_we   = s_we[g];
    assign m_addr = s_addr[g];
    assign m_byte = s_byte[g];
    assign m_di   = s_di[g];
    assign s_busy = s_cs & (~g_oh | {NUM_MST{m_busy}});
    assign accept = m_cs & ~m_busy;

    assign s_rvalid     = rd_owner_q;
    assign s_do         = m_do;
    assign conflict_cnt = conflict_q;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_req = |(s_cs & (s_cs - NUM_MST'(1)));

    always_comb begin
        lock_d     = m_cs & m_busy;
        lock_idx_d = (m_cs & m_busy) ? g : lock_idx_q;
        rd_owner_d = (accept & ~m_we) ? g_oh : '0;
        conflict_d = (multi_req && conflict_q != '1) ? conflict_q + 1'b1 : conflict_q;
    end

`ifdef MEM_ARB_HOLD_EN
    localparam int unsigned HOLD_W = ($clog2(HOLD_MAX + 1) > 3) ? $clog2(HOLD_MAX + 1) : 3;

    // While hold_cnt_q is non-zero, rr_ptr_q names the holding requestor.
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] run_len;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        run_len    = '0;
        if (hold_cnt_q != '0 && !s_cs[rr_ptr_q]) begin
            hold_cnt_d = '0;
            rr_ptr_d   = wrap_inc(rr_ptr_q);
        end
        if (accept) begin
            run_len = (hold_cnt_q != '0 && g == rr_ptr_q) ? hold_cnt_q + HOLD_W'(1)
                                                          : HOLD_W'(1);
            if (run_len == HOLD_W'(HOLD_MAX)) begin
                hold_cnt_d = '0;
                rr_ptr_d   = wrap_inc(g);
            end else begin
                hold_cnt_d = run_len;
                rr_ptr_d   = g;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    always_comb begin
        rr_ptr_d = accept ? wrap_inc(g) : rr_ptr_q;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rd_owner_q <= '0;
            conflict_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rd_owner_q <= rd_owner_d;
            conflict_q <= conflict_d;
        end
    end

endmodule

// File: tb/tb_mem_arb_n.sv
// Scoreboard bench for mem_arb_n: the driver pushes per-cycle expectations from a reference model,
// a monitor pops and compares them against the DUT outputs.
module tb_mem_arb_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int HOLD_MAX = 4;
`ifdef MEM_ARB_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N-1:0]            s_cs, s_we;
    logic [N-1:0][AW-1:0]    s_addr;
    logic [N-1:0][BW-1:0]    s_byte;
    logic [N-1:0][DW-1:0]    s_di;
    logic [DW-1:0]           s_do;
    logic [N-1:0]            s_rvalid, s_busy;
    logic                    m_cs, m_we;
    logic [AW-1:0]           m_addr;
    logic [BW-1:0]           m_byte;
    logic [DW-1:0]           m_di, m_do;
    logic                    m_busy;
    logic [15:0]             conflict_cnt;

    always #5 clk = ~clk;

    mem_arb_n #(
        .NUM_MST  (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_cs         (s_cs),
        .s_we         (s_we),
        .s_addr       (s_addr),
        .s_byte       (s_byte),
        .s_di         (s_di),
        .s_do         (s_do),
        .s_rvalid     (s_rvalid),
        .s_busy       (s_busy),
        .m_cs         (m_cs),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_byte       (m_byte),
        .m_di         (m_di),
        .m_do         (m_do),
        .m_busy       (m_busy),
        .conflict_cnt (conflict_cnt)
    );

    typedef struct {
        logic          m_cs;
        logic [AW-1:0] m_addr;
        logic          m_we;
        logic [BW-1:0] m_byte;
        logic [DW-1:0] m_di;
        logic [N-1:0]  s_busy;
        logic [N-1:0]  s_rvalid;
        logic [DW-1:0] s_do;
        logic [15:0]   cc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    // Request fields staged by the stimulus; applied to the DUT at the next cycle start.
    logic [N-1:0]         f_we;
    logic [N-1:0][AW-1:0] f_addr;
    logic [N-1:0][BW-1:0] f_byte;
    logic [N-1:0][DW-1:0] f_di;

    // Reference model state.
    int ptr, lk, lk_who, pend, cc, run_who, run_len, last_g;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus. dg/drv/dcc >= 0 pin the expected grant index, s_rvalid and
    // conflict_cnt to hand-derived constants; -1 leaves them to the model.
    task automatic cycle(input logic [N-1:0] cs, input logic busy, input logic r,
                         input int dg, input int drv, input int dcc);
        exp_t e;
        int   g;
        int   ng;
        bit   acc;
        @(negedge clk);
        rst    = r;
        s_cs   = cs;
        m_busy = busy;
        s_we   = f_we;
        s_addr = f_addr;
        s_byte = f_byte;
        s_di   = f_di;
        m_do   = $urandom;
        if (r) begin
            ptr = 0; lk = 0; pend = -1; cc = 0; run_len = 0;
        end
        g = -1;
        if (lk != 0 && cs[lk_who]) g = lk_who;
        else for (int k = 0; k < N; k++) if (g < 0 && cs[(ptr + k) % N]) g = (ptr + k) % N;
        ng = (dg >= 0) ? dg : ((g < 0) ? 0 : g);
        e.m_cs   = (cs != '0);
        e.m_addr = f_addr[ng];
        e.m_we   = f_we[ng];
        e.m_byte = f_byte[ng];
        e.m_di   = f_di[ng];
        for (int i = 0; i < N; i++) e.s_busy[i] = cs[i] && (i != ng || busy);
        e.s_rvalid = '0;
        if (pend >= 0 && !r) e.s_rvalid[pend] = 1'b1;
        if (drv >= 0) e.s_rvalid = N'(drv);
        e.s_do = m_do;
        e.cc   = (dcc >= 0) ? 16'(dcc) : 16'(cc);
        exp_q.push_back(e);

        last_g = -1;
        if (!r) begin
            acc = (cs != '0) && !busy;
            if ($countones(cs) >= 2 && cc < 65535) cc++;
            pend = (acc && !f_we[g]) ? g : -1;
            lk   = ((cs != '0) && busy) ? 1 : 0;
            if (lk != 0) lk_who = g;
`ifdef MEM_ARB_HOLD_EN
            if (run_len > 0 && !cs[run_who]) begin
                run_len = 0;
                ptr     = (run_who + 1) % N;
            end
            if (acc) begin
                if (run_len > 0 && run_who == g) run_len++;
                else begin
                    run_who = g;
                    run_len = 1;
                end
                if (run_len == HOLD_MAX) begin
                    run_len = 0;
                    ptr     = (g + 1) % N;
                end else ptr = g;
            end
`else
            if (acc) ptr = (g + 1) % N;
`endif
            if (acc) last_g = g;
        end
    endtask

    // Monitor: compares every presented cycle against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("m_cs", 64'(m_cs), 64'(mon_e.m_cs));
                if (mon_e.m_cs) begin
                    chk("m_addr", 64'(m_addr), 64'(mon_e.m_addr));
                    chk("m_we", 64'(m_we), 64'(mon_e.m_we));
                    chk("m_byte", 64'(m_byte), 64'(mon_e.m_byte));
                    chk("m_di", 64'(m_di), 64'(mon_e.m_di));
                end
                chk("s_busy", 64'(s_busy), 64'(mon_e.s_busy));
                chk("s_rvalid", 64'(s_rvalid), 64'(mon_e.s_rvalid));
                if (mon_e.s_rvalid != '0) chk("s_do", 64'(s_do), 64'(mon_e.s_do));
                chk("conflict_cnt", 64'(conflict_cnt), 64'(mon_e.cc));
            end
        end
    end

    logic [N-1:0] want;
    logic         rr;
    int           pat_h[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int           pat_n[8] = '{0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        rst = 1'b1; s_cs = '0; s_we = '0; s_addr = '0; s_byte = '0; s_di = '0;
        m_do = '0; m_busy = 1'b0;
        ptr = 0; lk = 0; lk_who = 0; pend = -1; cc = 0; run_who = 0; run_len = 0; last_g = -1;
        for (int i = 0; i < N; i++) begin
            f_we[i]   = 1'b1;
            f_addr[i] = AW'(32'h1000 * i);
            f_byte[i] = BW'(4'hF);
            f_di[i]   = DW'(32'hD000 + i);
        end

        cycle('0, 1'b0, 1'b1, -1, 0, 0);
        cycle('0, 1'b0, 1'b1, -1, 0, 0);

        // Four-way contention from reset: 0,1,2,3 (held 0,0,0,0); four conflict cycles.
        for (int k = 0; k < 4; k++) cycle(4'b1111, 1'b0, 1'b0, HOLD ? 0 : k, 0, k);
        cycle(4'b0000, 1'b0, 1'b0, -1, 0, 4);

        // Master 2 read locked through a 3-cycle stall, master 0 arrives mid-stall.
        f_we[2] = 1'b0; f_addr[2] = 32'h100; f_we[0] = 1'b1;
        cycle(4'b0100, 1'b1, 1'b0, 2, 0, -1);
        cycle(4'b0101, 1'b1, 1'b0, 2, 0, -1);
        cycle(4'b0101, 1'b1, 1'b0, 2, 0, -1);
        cycle(4'b0101, 1'b0, 1'b0, 2, 0, -1);
        cycle(4'b0001, 1'b0, 1'b0, 0, 4'b0100, -1);
        cycle(4'b0000, 1'b0, 1'b0, -1, 0, -1);

        // Back-to-back reads by masters 1 and 3.
        f_we[1] = 1'b0; f_addr[1] = 32'h10; f_we[3] = 1'b0; f_addr[3] = 32'h20;
        cycle(4'b1010, 1'b0, 1'b0, 1, 0, -1);
        cycle(4'b1000, 1'b0, 1'b0, 3, 4'b0010, -1);
        cycle(4'b0000, 1'b0, 1'b0, -1, 4'b1000, -1);

        // Masters 0 and 1 requesting continuously.
        f_we = '1;
        for (int k = 0; k < 8; k++) cycle(4'b0011, 1'b0, 1'b0, HOLD ? pat_h[k] : pat_n[k], 0, -1);
        cycle(4'b0000, 1'b0, 1'b0, -1, 0, -1);

        // Reset right after a read acceptance drops the read and restarts the pointer at 0.
        f_we[2] = 1'b0;
        cycle(4'b0100, 1'b0, 1'b0, 2, 0, -1);
        cycle(4'b0000, 1'b0, 1'b1, -1, 0, 0);
        cycle(4'b0000, 1'b0, 1'b1, -1, 0, 0);
        cycle(4'b1100, 1'b0, 1'b0, 2, 0, 0);
        cycle(4'b0000, 1'b0, 1'b0, -1, 4'b0100, 1);

        // Random traffic: requests stay up until accepted, occasional drops and resets.
        want = '0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!want[i] && $urandom_range(1, 0) == 1) begin
                    want[i]   = 1'b1;
                    f_we[i]   = 1'($urandom);
                    f_addr[i] = AW'($urandom);
                    f_byte[i] = BW'($urandom);
                    f_di[i]   = DW'($urandom);
                end else if (want[i] && $urandom_range(63, 0) == 0) begin
                    want[i] = 1'b0;
                end
            end
            rr = ($urandom_range(199, 0) == 0);
            cycle(want, $urandom_range(2, 0) == 0, rr, -1, -1, -1);
            if (last_g >= 0) want[last_g] = 1'b0;
            if (rr) want = '0;
        end

        // Long contention: counter must saturate and not wrap.
        for (int t = 0; t < 70000; t++) cycle(4'b1111, 1'b1, 1'b0, -1, -1, -1);
        cycle(4'b1111, 1'b1, 1'b0, -1, -1, 16'hFFFF);
        cycle(4'b0000, 1'b0, 1'b0, -1, 0, 16'hFFFF);

        @(negedge clk);
        #4;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
